// File: rtl/shift_rx8_defs.sv
// rtl/shift_rx8_defs.sv - shared constants and state encoding for the serial word receiver
//
// Purpose: frame levels, word width and FSM state type used by shift_rx8.
// Ports:   none (package).

package shift_rx8_defs;

   localparam int DW = 8;

   localparam logic START_LVL = 1'b0;
   localparam logic STOP_LVL  = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } state_t;

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchronizer for an asynchronous pin, resets to 1
//
// Purpose: bring an asynchronous, idle-high pin into the clk domain.
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset, forces both flops to 1
//   d    - asynchronous input
//   q    - synchronized output (2-cycle latency)

module sync2 (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= 1'b1;
         q    <= 1'b1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/shift_rx8.sv
// rtl/shift_rx8.sv - serial-to-parallel receiver for start/8 data MSB-first/stop frames
//
// Purpose: samples the serial line at a fixed 2^NP-clock bit period and
//          presents each correctly framed word in parallel.
// Ports:
//   clk   - system clock
//   rst   - synchronous active-high reset
//   din   - serial line, idles high, asynchronous to clk
//   data  - last correctly framed word
//   valid - one-cycle pulse when data is updated
//   ferr  - one-cycle pulse when the stop bit is low
//   busy  - high while a frame is being received

module shift_rx8
   import shift_rx8_defs::*;
#(
   parameter int NP = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          din,
   output logic [DW-1:0] data,
   output logic          valid,
   output logic          ferr,
   output logic          busy
);

   // Mid-bit sample point for the start bit, end-of-bit for the rest.
   localparam logic [NP-1:0] CNT_HALF = NP'((1 << (NP - 1)) - 1);
   localparam logic [NP-1:0] CNT_FULL = '1;
   localparam logic [NP-1:0] CNT_ONE  = NP'(1);

   logic          din_s;
   logic          din_p;
   state_t        state;
   state_t        state_nx;
   logic [NP-1:0] cnt;
   logic [2:0]    bitn;
   logic [DW-1:0] sr;
   logic          shift_en;
   logic          load;
   logic          err;

   sync2 u_sync (
      .clk (clk),
      .rst (rst),
      .d   (din),
      .q   (din_s)
   );

   always_comb begin
      state_nx = state;
      shift_en = 1'b0;
      load     = 1'b0;
      err      = 1'b0;
      case (state)
         ST_IDLE: begin
            // Only a genuine high-to-low transition starts a frame, so a
            // line stuck low after a framing error stays idle.
            if (din_p == STOP_LVL && din_s == START_LVL)
               state_nx = ST_START;
         end
         ST_START: begin
            if (cnt == CNT_HALF) begin
               if (din_s == START_LVL)
                  state_nx = ST_DATA;
               else
                  state_nx = ST_IDLE;
            end
         end
         ST_DATA: begin
            if (cnt == CNT_FULL) begin
               shift_en = 1'b1;
               if (bitn == 3'(DW - 1))
                  state_nx = ST_STOP;
            end
         end
         ST_STOP: begin
            if (cnt == CNT_FULL) begin
               state_nx = ST_IDLE;
               if (din_s == STOP_LVL)
                  load = 1'b1;
               else
                  err = 1'b1;
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         din_p <= 1'b1;
         cnt   <= '0;
         bitn  <= '0;
         sr    <= '0;
         data  <= '0;
         valid <= 1'b0;
         ferr  <= 1'b0;
         busy  <= 1'b0;
      end else begin
         state <= state_nx;
         din_p <= din_s;

         // cnt restarts on every state change; the full-bit compare in
         // DATA relies on the natural NP-bit wrap between bits.
         if (state_nx != state || state == ST_IDLE)
            cnt <= '0;
         else
            cnt <= cnt + CNT_ONE;

         if (state_nx == ST_DATA && state != ST_DATA)
            bitn <= '0;
         else if (shift_en)
            bitn <= bitn + 3'd1;

         if (shift_en)
            sr <= {sr[DW-2:0], din_s};

         if (load)
            data <= sr;

         valid <= load;
         ferr  <= err;
         busy  <= (state_nx != ST_IDLE);
      end
   end

endmodule
